dm_bus_bridge: RTL and testbench
================================

# dm_bus_bridge

Sequential bridge between the single-cycle core's data-memory port and a valid/ready system bus, sitting directly downstream of the core's load/store path. It latches one core access (load or byte-masked store), issues it as a word-aligned bus request, waits for the response, and holds the core in stall until the access completes. Load data is returned as the raw aligned word; the core's load/store unit performs lane selection and extension.

## Interface
Parameters:
- `ADDR_W`, 32: address width (equals `WORD_SIZE`).
- `DATA_W`, 32: data width (equals `WORD_SIZE`).
- `TIMEOUT_CYCLES`, 255: watchdog limit in cycles; used only with `DM_BRIDGE_TIMEOUT_EN`. Must be ≥1.

Ports:
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_DM_addr`  in  ADDR_W  core byte address.
- `i_DM_wd`  in  DATA_W  core store data, already lane-aligned.
- `i_DM_wen`  in  4  core byte write enables; nonzero means store.
- `i_DM_ren`  in  1  core load request.
- `o_DM_rd`  out  DATA_W  load data returned to the core.
- `o_stall`  out  1  hold PC and register-file write while high.
- `o_err`  out  1  one-cycle pulse when an access completes with an error.
- `o_bus_req_valid`  out  1  request valid.
- `i_bus_req_ready`  in  1  request accepted.
- `o_bus_addr`  out  ADDR_W  word address: `{addr[ADDR_W-1:2],2'b00}`.
- `o_bus_we`  out  1  write request.
- `o_bus_wstrb`  out  4  byte strobes; `4'b0000` for reads.
- `o_bus_wdata`  out  DATA_W  write data.
- `i_bus_rsp_valid`  in  1  response valid.
- `i_bus_rsp_err`  in  1  response error, qualified by `i_bus_rsp_valid`.
- `i_bus_rdata`  in  DATA_W  response data.
- `o_bus_rsp_ready`  out  1  ready to take a response.

## Operation
- The FSM has four states: IDLE, REQ, RSP, DONE.
- **IDLE**
  - An access is `i_DM_ren | (|i_DM_wen)`.
  - On an access: capture addr, wd, wen, and `we = |i_DM_wen`, then go to REQ.
  - If both load and store are asserted, the store wins. No error is flagged.
- **REQ**
  - Drive `o_bus_req_valid=1` with the captured fields.
  - Address, data, and strobes are stable from the registers and do not change while valid is high.
  - When `i_bus_req_ready` is high, go to RSP.
- **RSP**
  - Drive `o_bus_rsp_ready=1`.
  - When `i_bus_rsp_valid` is high: register `rd = i_bus_rsp_err ? 0 : i_bus_rdata`, register `err = i_bus_rsp_err`, and go to DONE.
  - For stores, `i_bus_rdata` is still captured but has no effect on the core.
- **DONE**
  - `o_stall=0`; the core retires the instruction on this edge.
  - `o_err` equals the registered `err`.
  - Go to IDLE unconditionally. A new access is therefore detected one cycle after DONE.
- **Stall and data outputs**
  - `o_stall = (IDLE & access) | REQ | RSP`. The IDLE term is combinational from the core inputs.
  - `o_DM_rd` holds the last captured value until the next capture.
- **Reset**
  - Reset in any state returns to IDLE immediately and drops valid/ready.
  - Any in-flight bus transaction is abandoned; the bus must be reset in the same cycle.

## Timing
- Reset values:
  - `o_stall=0` while the access inputs are low.
  - `o_err=0`, `o_DM_rd=0`.
  - `o_bus_req_valid=0`, `o_bus_rsp_ready=0`, `o_bus_we=0`.
  - `o_bus_wstrb=0`, `o_bus_addr=0`, `o_bus_wdata=0`.
- Minimum access, with ready and rsp_valid both at their first opportunity, takes 4 cycles: IDLE → REQ → RSP → DONE. Stall is high for 3 cycles.
- Each cycle of ready-low adds one REQ cycle. Each cycle of rsp-valid-low adds one RSP cycle.
- A response arriving during REQ is ignored; the bus must not respond before acceptance.
- At most one transaction is outstanding.

## Configuration
- **`DM_BRIDGE_TIMEOUT_EN` defined:**
  - A counter clears on entry to REQ and increments in each REQ or RSP cycle.
  - When the count reaches `TIMEOUT_CYCLES` without completion, the FSM goes to DONE with `rd=0` and `err=1`.
  - Valid/ready drop on that exit.
  - A late response after timeout is neither accepted nor forwarded.
- **Undefined:** no counter; the bridge waits indefinitely.

## Test plan
- Store `addr=0x1003`, `wen=4'b1000`, `wd=0xAB000000`, bus ready and response immediate → bus sees `addr=0x1000`, `we=1`, `wstrb=1000`, `wdata=0xAB000000`; stall high exactly 3 cycles; `o_err=0`.
- Load `addr=0x2000`, ready delayed 2 cycles, response delayed 3 cycles with `rdata=0xDEADBEEF` → stall high 8 cycles; `o_DM_rd=0xDEADBEEF` in DONE; `wstrb=0`, `we=0`.
- Load with `i_bus_rsp_err=1`, `rdata=0x12345678` → `o_DM_rd=0`; `o_err` pulses high for exactly the DONE cycle.
- `ren=1` and `wen=4'b0011` together → write issued with `wstrb=0011`; no error.
- `i_rst` asserted during RSP → next cycle IDLE; `rsp_ready=0`; stall follows the inputs only; `o_err=0`.
- With `DM_BRIDGE_TIMEOUT_EN` and `TIMEOUT_CYCLES=4`, `i_bus_req_ready` held low → DONE reached after 4 REQ cycles; `o_err=1`; `o_DM_rd=0`; `o_bus_req_valid=0` thereafter.

Source files
------------

// File: rtl/dm_bus_bridge.sv
// dm_bus_bridge: converts one core data-memory access (load or byte-masked
// store) into a single word-aligned valid/ready bus transaction and stalls
// the core until the response returns.
// Optional feature: define DM_BRIDGE_TIMEOUT_EN to enable a watchdog that
// aborts an access with an error after TIMEOUT_CYCLES REQ/RSP cycles.
module dm_bus_bridge #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_DM_addr,
  input  logic [DATA_W-1:0] i_DM_wd,
  input  logic [3:0]        i_DM_wen,
  input  logic              i_DM_ren,
  output logic [DATA_W-1:0] o_DM_rd,
  output logic              o_stall,
  output logic              o_err,
  output logic              o_bus_req_valid,
  input  logic              i_bus_req_ready,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic              o_bus_we,
  output logic [3:0]        o_bus_wstrb,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic              i_bus_rsp_valid,
  input  logic              i_bus_rsp_err,
  input  logic [DATA_W-1:0] i_bus_rdata,
  output logic              o_bus_rsp_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_access;
  logic              w_capture;
  logic              w_complete;
  logic              w_tmo_exit;
  logic              w_timeout;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wd;
  logic [3:0]        r_wstrb;
  logic              r_we;
  logic [DATA_W-1:0] r_rd;
  logic              r_err;

  // Byte offset bits are dropped on the bus; TIMEOUT_CYCLES is only
  // consumed when the watchdog is built in.
  logic              w_unused;
  assign w_unused = ^{i_DM_addr[1:0], (TIMEOUT_CYCLES == 0)};

  assign w_access = i_DM_ren | (|i_DM_wen);

`ifdef DM_BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1) + 1;

  logic [CNT_W-1:0] r_cnt;

  // Watchdog counter: cleared when an access is latched, counts REQ/RSP cycles
  always_ff @(posedge i_clk) begin
    if (i_rst || w_capture) begin
      r_cnt <= '0;
    end else if ((r_state == S_REQ) || (r_state == S_RSP)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Current cycle is the TIMEOUT_CYCLES-th one spent waiting on the bus
  assign w_timeout = ((r_state == S_REQ) || (r_state == S_RSP)) &&
                     (r_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a bus handshake or response takes priority over timeout
  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_complete = 1'b0;
    w_tmo_exit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          w_capture = 1'b1;
          w_next    = S_REQ;
        end
      end
      S_REQ: begin
        if (i_bus_req_ready) begin
          w_next = S_RSP;
        end else if (w_timeout) begin
          w_tmo_exit = 1'b1;
          w_next     = S_DONE;
        end
      end
      S_RSP: begin
        if (i_bus_rsp_valid) begin
          w_complete = 1'b1;
          w_next     = S_DONE;
        end else if (w_timeout) begin
          w_tmo_exit = 1'b1;
          w_next     = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Request fields latched from the core; a store wins over a concurrent load
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr  <= '0;
      r_wd    <= '0;
      r_wstrb <= '0;
      r_we    <= 1'b0;
    end else if (w_capture) begin
      r_addr  <= {i_DM_addr[ADDR_W-1:2], 2'b00};
      r_wd    <= i_DM_wd;
      r_wstrb <= i_DM_wen;
      r_we    <= |i_DM_wen;
    end
  end

  // Response capture; load data is zeroed on error or timeout
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd  <= '0;
      r_err <= 1'b0;
    end else if (w_complete) begin
      r_rd  <= i_bus_rsp_err ? '0 : i_bus_rdata;
      r_err <= i_bus_rsp_err;
    end else if (w_tmo_exit) begin
      r_rd  <= '0;
      r_err <= 1'b1;
    end
  end

  // Output decode; stall includes the same-cycle access request seen in IDLE
  always_comb begin
    o_stall         = ((r_state == S_IDLE) && w_access) ||
                      (r_state == S_REQ) || (r_state == S_RSP);
    o_err           = (r_state == S_DONE) && r_err;
    o_DM_rd         = r_rd;
    o_bus_req_valid = (r_state == S_REQ);
    o_bus_rsp_ready = (r_state == S_RSP);
    o_bus_addr      = r_addr;
    o_bus_we        = r_we;
    o_bus_wstrb     = r_wstrb;
    o_bus_wdata     = r_wd;
  end

endmodule

// File: tb/tb_dm_bus_bridge.sv
// tb_dm_bus_bridge: directed and randomized accesses against a transaction-
// level expectation (word address, strobes, stall length, returned data).
module tb_dm_bus_bridge;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 16;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [AW-1:0] i_DM_addr;
  logic [DW-1:0] i_DM_wd;
  logic [3:0]    i_DM_wen;
  logic          i_DM_ren;
  logic [DW-1:0] o_DM_rd;
  logic          o_stall;
  logic          o_err;
  logic          o_bus_req_valid;
  logic          i_bus_req_ready;
  logic [AW-1:0] o_bus_addr;
  logic          o_bus_we;
  logic [3:0]    o_bus_wstrb;
  logic [DW-1:0] o_bus_wdata;
  logic          i_bus_rsp_valid;
  logic          i_bus_rsp_err;
  logic [DW-1:0] i_bus_rdata;
  logic          o_bus_rsp_ready;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] last_rd = '0;

  always #5 i_clk = ~i_clk;

  dm_bus_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_DM_addr(i_DM_addr), .i_DM_wd(i_DM_wd), .i_DM_wen(i_DM_wen), .i_DM_ren(i_DM_ren),
    .o_DM_rd(o_DM_rd), .o_stall(o_stall), .o_err(o_err),
    .o_bus_req_valid(o_bus_req_valid), .i_bus_req_ready(i_bus_req_ready),
    .o_bus_addr(o_bus_addr), .o_bus_we(o_bus_we), .o_bus_wstrb(o_bus_wstrb),
    .o_bus_wdata(o_bus_wdata), .i_bus_rsp_valid(i_bus_rsp_valid),
    .i_bus_rsp_err(i_bus_rsp_err), .i_bus_rdata(i_bus_rdata),
    .o_bus_rsp_ready(o_bus_rsp_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One complete access: d1 extra ready-low cycles, d2 extra rsp-valid-low cycles
  task automatic run_access(input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] wen, input logic ren,
                            input int d1, input int d2,
                            input logic err, input logic [31:0] rdata);
    logic        exp_we;
    logic [3:0]  exp_strb;
    logic [31:0] exp_rd;
    int          stalls;
    exp_we   = (wen != 4'b0000);
    exp_strb = exp_we ? wen : 4'b0000;
    exp_rd   = err ? 32'h0 : rdata;
    stalls   = 0;
    @(negedge i_clk);
    i_DM_addr = addr; i_DM_wd = wd; i_DM_wen = wen; i_DM_ren = ren;
    #1;
    check("idle_stall", 32'(o_stall), 32'd1);
    check("idle_valid", 32'(o_bus_req_valid), 32'd0);
    stalls += int'(o_stall);
    @(posedge i_clk);
    for (int k = 0; k <= d1; k++) begin
      @(negedge i_clk);
      #1;
      check("req_valid", 32'(o_bus_req_valid), 32'd1);
      check("req_addr", o_bus_addr, addr & 32'hFFFF_FFFC);
      check("req_we", 32'(o_bus_we), 32'(exp_we));
      check("req_wstrb", 32'(o_bus_wstrb), 32'(exp_strb));
      if (exp_we) check("req_wdata", o_bus_wdata, wd);
      check("req_rd_hold", o_DM_rd, last_rd);
      stalls += int'(o_stall);
      i_bus_req_ready = (k == d1);
      @(posedge i_clk);
    end
    for (int k = 0; k <= d2; k++) begin
      @(negedge i_clk);
      i_bus_req_ready = 1'b0;
      #1;
      check("rsp_ready", 32'(o_bus_rsp_ready), 32'd1);
      check("rsp_valid_low", 32'(o_bus_req_valid), 32'd0);
      stalls += int'(o_stall);
      i_bus_rsp_valid = (k == d2);
      i_bus_rsp_err   = (k == d2) ? err : 1'($urandom);
      i_bus_rdata     = (k == d2) ? rdata : $urandom;
      @(posedge i_clk);
    end
    @(negedge i_clk);
    i_bus_rsp_valid = 1'b0;
    #1;
    check("done_stall", 32'(o_stall), 32'd0);
    check("done_err", 32'(o_err), 32'(err));
    check("done_rd", o_DM_rd, exp_rd);
    check("done_rsp_ready", 32'(o_bus_rsp_ready), 32'd0);
    check("stall_cycles", 32'(stalls), 32'(3 + d1 + d2));
    last_rd = exp_rd;
    i_DM_wen = 4'b0000; i_DM_ren = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    #1;
    check("post_err", 32'(o_err), 32'd0);
    check("post_stall", 32'(o_stall), 32'd0);
    check("post_rd_hold", o_DM_rd, last_rd);
  endtask

  initial begin
    i_rst = 1'b1;
    i_DM_addr = '0; i_DM_wd = '0; i_DM_wen = '0; i_DM_ren = 1'b0;
    i_bus_req_ready = 1'b0; i_bus_rsp_valid = 1'b0; i_bus_rsp_err = 1'b0; i_bus_rdata = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_rd", o_DM_rd, 32'd0);
    check("rst_valid", 32'(o_bus_req_valid), 32'd0);
    check("rst_rsp_ready", 32'(o_bus_rsp_ready), 32'd0);
    check("rst_we", 32'(o_bus_we), 32'd0);
    check("rst_wstrb", 32'(o_bus_wstrb), 32'd0);
    check("rst_addr", o_bus_addr, 32'd0);
    check("rst_wdata", o_bus_wdata, 32'd0);

    // Directed accesses
    run_access(32'h0000_1003, 32'hAB00_0000, 4'b1000, 1'b0, 0, 0, 1'b0, 32'h5555_AAAA);
    run_access(32'h0000_2000, 32'h0, 4'b0000, 1'b1, 2, 3, 1'b0, 32'hDEAD_BEEF);
    run_access(32'h0000_3004, 32'h0, 4'b0000, 1'b1, 0, 1, 1'b1, 32'h1234_5678);
    run_access(32'h0000_4002, 32'h0000_BEEF, 4'b0011, 1'b1, 1, 0, 1'b0, 32'h0BAD_F00D);

    // Randomized accesses
    for (int n = 0; n < 40; n++) begin
      logic [3:0] wen;
      logic       ren;
      wen = (($urandom % 2) == 0) ? 4'($urandom) : 4'b0000;
      ren = (wen == 4'b0000) ? 1'b1 : 1'($urandom);
      run_access($urandom, $urandom, wen, ren, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), (($urandom % 5) == 0), $urandom);
    end

    // Reset while waiting for a response
    @(negedge i_clk);
    i_DM_addr = 32'h0000_5000; i_DM_ren = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_bus_req_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_bus_req_ready = 1'b0;
    #1;
    check("pre_rst_rsp_ready", 32'(o_bus_rsp_ready), 32'd1);
    i_rst = 1'b1; i_DM_ren = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("mid_rst_rsp_ready", 32'(o_bus_rsp_ready), 32'd0);
    check("mid_rst_valid", 32'(o_bus_req_valid), 32'd0);
    check("mid_rst_stall", 32'(o_stall), 32'd0);
    check("mid_rst_err", 32'(o_err), 32'd0);
    check("mid_rst_rd", o_DM_rd, 32'd0);
    i_DM_ren = 1'b1;
    #1;
    check("mid_rst_stall_follow", 32'(o_stall), 32'd1);
    i_DM_ren = 1'b0;
    last_rd = 32'h0;
    @(posedge i_clk);
    run_access(32'h0000_6008, 32'h0, 4'b0000, 1'b1, 0, 0, 1'b0, 32'hCAFE_0001);

`ifdef DM_BRIDGE_TIMEOUT_EN
    // Request never accepted: watchdog aborts after TMO REQ cycles
    @(negedge i_clk);
    i_DM_addr = 32'h0000_7000; i_DM_ren = 1'b1;
    @(posedge i_clk);
    for (int k = 0; k < int'(TMO); k++) begin
      @(negedge i_clk);
      #1;
      check("tmo_req_valid", 32'(o_bus_req_valid), 32'd1);
      @(posedge i_clk);
    end
    @(negedge i_clk);
    #1;
    check("tmo_done_valid", 32'(o_bus_req_valid), 32'd0);
    check("tmo_done_err", 32'(o_err), 32'd1);
    check("tmo_done_rd", o_DM_rd, 32'd0);
    check("tmo_done_stall", 32'(o_stall), 32'd0);
    i_DM_ren = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    #1;
    check("tmo_post_valid", 32'(o_bus_req_valid), 32'd0);
    check("tmo_post_err", 32'(o_err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
